vid_fetch_ctrl: RTL and testbench



---
 rtl/vid_pkg.sv | 45 ++++
 rtl/vid_fetch_ctrl_if.sv | 28 ++
 rtl/vid_addr_walker.sv | 64 ++++++
 rtl/vid_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_vid_fetch_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vid_pkg.sv
// Shared types and constants for the video pixel fetch controller.
// Holds the FSM state encoding, bus command/request/length codes, the pixel
// payload struct and the FIFO credit helper used by the scheduler.
package vid_pkg;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned BURST_LEN  = 4;
    localparam int unsigned LVL_W      = 5;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned CNT_W      = 13;
    localparam int unsigned PIX_W      = 24;
    localparam int unsigned BEAT_W     = 2;
    localparam int unsigned WDOG_W     = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FRAME_WAIT = 3'd1,
        CHECK      = 3'd2,
        REQ        = 3'd3,
        ADDR       = 3'd4,
        DATA       = 3'd5,
        NEXT       = 3'd6
    } fetch_state_t;

    localparam logic [2:0] CMD_IDLE   = 3'b000;
    localparam logic [2:0] CMD_WR     = 3'b001;
    localparam logic [2:0] CMD_RD     = 3'b010;
    localparam logic [2:0] CMD_RDDATA = 3'b011;
    localparam logic [1:0] REQ_BID    = 2'b11;
    localparam logic [1:0] REQ_NONE   = 2'b00;
    localparam logic [1:0] LEN_4      = 2'b10;
    localparam logic [1:0] LEN_NONE   = 2'b00;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // True when a full burst fits in the FIFO without overflow.
    function automatic logic credit_ok(input logic [LVL_W-1:0] level);
        return level <= LVL_W'(FIFO_DEPTH - BURST_LEN);
    endfunction

endpackage

// File: rtl/vid_fetch_ctrl_if.sv
// Bus and pixel-FIFO signal bundle for vid_fetch_ctrl.
// master: the fetch controller (drives requests and FIFO pushes).
// slave : arbiter/FIFO side (drives grant, read beats and FIFO level).
interface vid_fetch_ctrl_if;
    import vid_pkg::*;

    logic [1:0]        reqout;
    logic [2:0]        cmdout;
    logic [1:0]        lenout;
    logic [ADDR_W-1:0] addrdataout;
    logic              ackin;
    logic [2:0]        cmdin;
    logic [ADDR_W-1:0] addrdatain;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_write;
    pixel_t            fifo_data;

    modport master (
        input  ackin, cmdin, addrdatain, fifo_level,
        output reqout, cmdout, lenout, addrdataout, fifo_write, fifo_data
    );

    modport slave (
        output ackin, cmdin, addrdatain, fifo_level,
        input  reqout, cmdout, lenout, addrdataout, fifo_write, fifo_data
    );

endinterface

// File: rtl/vid_addr_walker.sv
// Frame-buffer address walker: tracks burst pointer, line start pointer,
// pixel and line counters.
// Ports: clk, reset_n (sync, active-low); i_load reloads from i_base;
// i_advance steps one burst (with line wrap); o_ptr is the next burst
// address; o_frame_last_c flags that the current burst ends the frame.
module vid_addr_walker
    import vid_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_lineinc,
    input  logic [CNT_W-1:0]  i_hsize,
    input  logic [CNT_W-1:0]  i_vsize,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_frame_last_c
);

    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(4 * BURST_LEN);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_line_ptr;
    logic [CNT_W-1:0]  r_pix_cnt;
    logic [CNT_W-1:0]  r_line_cnt;

    logic [CNT_W:0]    w_pix_sum;
    logic              w_line_end;
    logic [ADDR_W-1:0] w_next_line;

    // Extra bit on the sum so a large hsize cannot hide the line end.
    assign w_pix_sum      = (CNT_W+1)'(r_pix_cnt) + (CNT_W+1)'(BURST_LEN);
    assign w_line_end     = w_pix_sum >= (CNT_W+1)'(i_hsize);
    assign w_next_line    = r_line_ptr + i_lineinc;
    assign o_frame_last_c = w_line_end && ((r_line_cnt + CNT_W'(1)) == i_vsize);
    assign o_ptr          = r_ptr;

    // Pointer/counter update; load wins over advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_line_ptr <= '0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (i_load) begin
            r_ptr      <= i_base;
            r_line_ptr <= i_base;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (i_advance) begin
            if (w_line_end) begin
                r_line_ptr <= w_next_line;
                r_ptr      <= w_next_line;
                r_pix_cnt  <= '0;
                r_line_cnt <= r_line_cnt + CNT_W'(1);
            end else begin
                r_ptr      <= r_ptr + BURST_BYTES;
                r_pix_cnt  <= r_pix_cnt + CNT_W'(BURST_LEN);
            end
        end
    end

endmodule

// File: rtl/vid_fetch_ctrl.sv
// Video pixel fetch scheduler: issues one 4-beat read burst at a time on the
// shared bus while the pixel FIFOs have room, walks the frame buffer and
// pushes each returned beat into the RGB FIFOs one cycle later.
// Ports: clk, reset_n (sync, active-low); en, base_addr, lineinc, hsize,
// vsize, frame_start (configuration/timing); bus (master modport: request,
// command, address, grant, read beats, FIFO level and push); busy,
// frame_done (status).
// Build option: FETCH_TIMEOUT_EN adds an 8-bit stall watchdog and fetch_err.
module vid_fetch_ctrl
    import vid_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] lineinc,
    input  logic [CNT_W-1:0]  hsize,
    input  logic [CNT_W-1:0]  vsize,
    input  logic              frame_start,
    vid_fetch_ctrl_if.master  bus,
    output logic              busy,
    output logic              frame_done
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              fetch_err
`endif
);

    localparam logic [2:0] S_IDLE       = IDLE;
    localparam logic [2:0] S_FRAME_WAIT = FRAME_WAIT;
    localparam logic [2:0] S_CHECK      = CHECK;
    localparam logic [2:0] S_REQ        = REQ;
    localparam logic [2:0] S_ADDR       = ADDR;
    localparam logic [2:0] S_DATA       = DATA;
    localparam logic [2:0] S_NEXT       = NEXT;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_pending;

    logic [1:0]        r_reqout;
    logic [2:0]        r_cmdout;
    logic [1:0]        r_lenout;
    logic [ADDR_W-1:0] r_addrdataout;
    logic              r_fifo_write;
    pixel_t            r_fifo_data;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_load;
    logic              w_advance;
    logic              w_beat;
    logic              w_frame_done;
    logic              w_size_ok;
    logic              w_in_burst;
    logic              w_frame_last;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_unused_hi;

    assign w_size_ok   = (hsize != '0) && (vsize != '0);
    assign w_beat      = (r_state == S_DATA) && (bus.cmdin == CMD_RDDATA);
    assign w_in_burst  = (r_state == S_REQ) || (r_state == S_ADDR) ||
                         (r_state == S_DATA) || (r_state == S_NEXT);
    assign w_unused_hi = ^bus.addrdatain[ADDR_W-1:PIX_W];

`ifdef FETCH_TIMEOUT_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              r_fetch_err;
    logic              w_stall;
    logic              w_timeout;

    assign w_stall   = ((r_state == S_REQ) && !bus.ackin) ||
                       ((r_state == S_DATA) && !w_beat);
    assign w_timeout = w_stall && (r_wdog == '1);
    assign fetch_err = r_fetch_err;

    // Stall watchdog; any progress or a timeout restarts it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wdog      <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= w_timeout;
            if (w_stall && !w_timeout) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end else begin
                r_wdog <= '0;
            end
        end
    end
`endif

    vid_addr_walker u_walker (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_load         (w_load),
        .i_advance      (w_advance),
        .i_base         (base_addr),
        .i_lineinc      (lineinc),
        .i_hsize        (hsize),
        .i_vsize        (vsize),
        .o_ptr          (w_ptr),
        .o_frame_last_c (w_frame_last)
    );

    // Next-state and walker control.
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && frame_start) begin
                    w_load = 1'b1;
                    w_next = w_size_ok ? S_CHECK : S_FRAME_WAIT;
                end
            end
            S_FRAME_WAIT: begin
                if (frame_start) begin
                    w_load = 1'b1;
                    if (w_size_ok) begin
                        w_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (!en) begin
                    w_next = S_IDLE;
                end else if (credit_ok(bus.fifo_level)) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.ackin) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                w_next = S_DATA;
            end
            S_DATA: begin
                if (w_beat && (r_beat_cnt == BEAT_W'(BURST_LEN - 1))) begin
                    w_next = S_NEXT;
                end
            end
            S_NEXT: begin
                // A frame_start seen during the burst restarts the frame here.
                if (r_pending || frame_start) begin
                    w_load = 1'b1;
                    w_next = en ? S_CHECK : S_IDLE;
                end else begin
                    w_advance = 1'b1;
                    if (!en) begin
                        w_next = S_IDLE;
                    end else if (w_frame_last) begin
                        w_frame_done = 1'b1;
                        w_next       = S_FRAME_WAIT;
                    end else begin
                        w_next = S_CHECK;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
`ifdef FETCH_TIMEOUT_EN
        if (w_timeout) begin
            w_next = S_NEXT;
        end
`endif
    end

    // State, burst bookkeeping and registered outputs keyed to the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_beat_cnt    <= '0;
            r_pending     <= 1'b0;
            r_reqout      <= REQ_NONE;
            r_cmdout      <= CMD_IDLE;
            r_lenout      <= LEN_NONE;
            r_addrdataout <= '0;
            r_fifo_write  <= 1'b0;
            r_fifo_data   <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_ADDR) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end

            if (r_state == S_NEXT) begin
                r_pending <= 1'b0;
            end else if (frame_start && w_in_burst) begin
                r_pending <= 1'b1;
            end

            r_reqout      <= ((w_next == S_REQ) || (w_next == S_ADDR) ||
                              (w_next == S_DATA)) ? REQ_BID : REQ_NONE;
            r_cmdout      <= (w_next == S_ADDR) ? CMD_RD : CMD_IDLE;
            r_lenout      <= (w_next == S_ADDR) ? LEN_4 : LEN_NONE;
            r_addrdataout <= (w_next == S_ADDR) ? w_ptr : '0;

            r_fifo_write <= w_beat;
            if (w_beat) begin
                r_fifo_data <= pixel_t'(bus.addrdatain[PIX_W-1:0]);
            end

            r_busy       <= (w_next != S_IDLE) && (w_next != S_FRAME_WAIT);
            r_frame_done <= w_frame_done;
        end
    end

    assign bus.reqout      = r_reqout;
    assign bus.cmdout      = r_cmdout;
    assign bus.lenout      = r_lenout;
    assign bus.addrdataout = r_addrdataout;
    assign bus.fifo_write  = r_fifo_write;
    assign bus.fifo_data   = r_fifo_data;
    assign busy            = r_busy;
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_vid_fetch_ctrl.sv
// Directed self-checking bench for vid_fetch_ctrl.
module tb_vid_fetch_ctrl;
    import vid_pkg::*;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [31:0] base_addr;
    logic [31:0] lineinc;
    logic [12:0] hsize;
    logic [12:0] vsize;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int fd_cnt   = 0;

    vid_fetch_ctrl_if bus_if ();

    vid_fetch_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .base_addr   (base_addr),
        .lineinc     (lineinc),
        .hsize       (hsize),
        .vsize       (vsize),
        .frame_start (frame_start),
        .bus         (bus_if),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err   (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.fifo_write === 1'b1) wr_cnt <= wr_cnt + 1;
        if (frame_done === 1'b1)        fd_cnt <= fd_cnt + 1;
    end

    // Bus responder for one burst: waits for the bid, grants after 2 cycles,
    // captures the address phase, then returns beats on the slots set in mask.
    task automatic serve_burst(
        input  logic [7:0]  mask,
        input  logic [2:0]  gap_cmd,
        input  int          drop_en_after,
        input  int          fs_slot,
        input  logic [23:0] seed,
        output logic [31:0] addr,
        output logic [2:0]  cmd,
        output logic [1:0]  len,
        output int          pushes,
        output int          bad,
        output logic        timed_out
    );
        int          w;
        int          nb;
        logic        beat;
        logic [23:0] pix;
        addr = '0; cmd = '0; len = '0; pushes = 0; bad = 0; timed_out = 1'b0; nb = 0;
        w = 0;
        while (bus_if.reqout !== REQ_BID && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (bus_if.reqout !== REQ_BID) begin
            timed_out = 1'b1;
            return;
        end
        repeat (2) @(negedge clk);
        bus_if.ackin = 1'b1;
        @(negedge clk);
        bus_if.ackin = 1'b0;
        addr = bus_if.addrdataout;
        cmd  = bus_if.cmdout;
        len  = bus_if.lenout;
        @(negedge clk);
        for (int s = 0; s < 8 && nb < NB; s++) begin
            beat = mask[s];
            pix  = seed + 24'(nb);
            if (nb == drop_en_after) en = 1'b0;
            bus_if.cmdin      = beat ? CMD_RDDATA : gap_cmd;
            bus_if.addrdatain = beat ? {8'hEE, pix} : 32'h5A5A_5A5A;
            frame_start       = (s == fs_slot);
            @(negedge clk);
            frame_start = 1'b0;
            if (beat) begin
                if (bus_if.fifo_write === 1'b1 && bus_if.fifo_data === pix) pushes++;
                else bad++;
                nb++;
            end else if (bus_if.fifo_write !== 1'b0) begin
                bad++;
            end
        end
        bus_if.cmdin      = CMD_IDLE;
        bus_if.addrdatain = '0;
        if (nb < NB) timed_out = 1'b1;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; frame_start = 1'b0;
        base_addr = 32'h1000; lineinc = 32'h400; hsize = 13'd8; vsize = 13'd2;
        bus_if.ackin = 1'b0; bus_if.cmdin = CMD_IDLE; bus_if.addrdatain = '0;
        bus_if.fifo_level = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.reqout !== 2'b00) begin n_fail++; $display("FAIL reset_reqout got=%b exp=00", bus_if.reqout); end
        n_checks++; if (bus_if.cmdout !== 3'b000) begin n_fail++; $display("FAIL reset_cmdout got=%b exp=000", bus_if.cmdout); end
        n_checks++; if (bus_if.lenout !== 2'b00) begin n_fail++; $display("FAIL reset_lenout got=%b exp=00", bus_if.lenout); end
        n_checks++; if (bus_if.addrdataout !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus_if.addrdataout); end
        n_checks++; if (bus_if.fifo_write !== 1'b0 || bus_if.fifo_data !== 24'h0) begin n_fail++; $display("FAIL reset_fifo got=%b/%h exp=0/0", bus_if.fifo_write, bus_if.fifo_data); end
        n_checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_status got=%b%b exp=00", busy, frame_done); end
        reset_n = 1'b1;
        en = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.reqout !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start got=%b/%b exp=00/0", bus_if.reqout, busy); end
    endtask

    task automatic test_basic_frame();
        logic [31:0] exp_a;
        logic [31:0] addr;
        logic [2:0]  cmd;
        logic [1:0]  len;
        int          pushes, bad, wr0, fd0;
        logic        to;
        wr0 = wr_cnt; fd0 = fd_cnt;
        pulse_frame_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'h1000 + ((i >= 2) ? 32'h400 : 32'h0) + ((i % 2 == 1) ? 32'h10 : 32'h0);
            serve_burst(8'hFF, CMD_IDLE, -1, -1, 24'h100000 + 24'(i * 16), addr, cmd, len, pushes, bad, to);
            n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout burst=%0d", i); end
            n_checks++; if (addr !== exp_a) begin n_fail++; $display("FAIL basic_addr burst=%0d got=%h exp=%h", i, addr, exp_a); end
            n_checks++; if (cmd !== CMD_RD || len !== LEN_4) begin n_fail++; $display("FAIL basic_cmdlen burst=%0d got=%b/%b exp=010/10", i, cmd, len); end
            n_checks++; if (pushes != 4 || bad != 0) begin n_fail++; $display("FAIL basic_push burst=%0d got=%0d bad=%0d exp=4/0", i, pushes, bad); end
        end
        @(negedge clk);
        n_checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_frame_done got=%b/%b exp=1/0", frame_done, busy); end
        repeat (5) @(negedge clk);
        n_checks++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL basic_fd_count got=%0d exp=1", fd_cnt - fd0); end
        n_checks++; if (wr_cnt - wr0 != 16) begin n_fail++; $display("FAIL basic_wr_count got=%0d exp=16", wr_cnt - wr0); end
        n_checks++; if (bus_if.reqout !== 2'b00) begin n_fail++; $display("FAIL basic_wait_req got=%b exp=00", bus_if.reqout); end
    endtask

    task automatic test_credit();
        int bad_req;
        bus_if.fifo_level = 5'd13;
        pulse_frame_start();
        bad_req = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.reqout !== 2'b00) bad_req++;
        end
        n_checks++; if (bad_req != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL credit_hold got=%0d bids busy=%b exp=0/1", bad_req, busy); end
        bus_if.fifo_level = 5'd12;
        @(negedge clk);
        n_checks++; if (bus_if.reqout !== REQ_BID) begin n_fail++; $display("FAIL credit_launch got=%b exp=11", bus_if.reqout); end
        bus_if.fifo_level = 5'd0;
    endtask

    task automatic test_beat_gaps();
        logic [31:0] addr;
        logic [2:0]  cmd;
        logic [1:0]  len;
        int          pushes, bad, wr0;
        logic        to;
        wr0 = wr_cnt;
        // Beats on slots 0, 2, 5, 6; gaps carry a non-data command.
        serve_burst(8'b0110_0101, CMD_WR, -1, -1, 24'h3C0000, addr, cmd, len, pushes, bad, to);
        n_checks++; if (to !== 1'b0 || addr !== 32'h1000) begin n_fail++; $display("FAIL gaps_addr got=%h to=%b exp=1000/0", addr, to); end
        n_checks++; if (pushes != 4 || bad != 0) begin n_fail++; $display("FAIL gaps_push got=%0d bad=%0d exp=4/0", pushes, bad); end
        repeat (2) @(negedge clk);
        n_checks++; if (wr_cnt - wr0 != 4) begin n_fail++; $display("FAIL gaps_wr_count got=%0d exp=4", wr_cnt - wr0); end
    endtask

    task automatic test_en_drop();
        logic [31:0] addr;
        logic [2:0]  cmd;
        logic [1:0]  len;
        int          pushes, bad, wr0, bad_req;
        logic        to;
        serve_burst(8'hFF, CMD_IDLE, 2, -1, 24'h777700, addr, cmd, len, pushes, bad, to);
        n_checks++; if (to !== 1'b0 || addr !== 32'h1010) begin n_fail++; $display("FAIL endrop_addr got=%h to=%b exp=1010/0", addr, to); end
        n_checks++; if (pushes != 4 || bad != 0) begin n_fail++; $display("FAIL endrop_push got=%0d bad=%0d exp=4/0", pushes, bad); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || bus_if.reqout !== 2'b00) begin n_fail++; $display("FAIL endrop_idle got=%b/%b exp=0/00", busy, bus_if.reqout); end
        wr0 = wr_cnt; bad_req = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.reqout !== 2'b00) bad_req++;
        end
        n_checks++; if (bad_req != 0 || wr_cnt != wr0) begin n_fail++; $display("FAIL endrop_quiet got=%0d bids %0d writes exp=0/0", bad_req, wr_cnt - wr0); end
    endtask

    task automatic test_frame_start_mid();
        logic [31:0] addr;
        logic [2:0]  cmd;
        logic [1:0]  len;
        int          pushes, bad, fd0;
        logic        to;
        en = 1'b1;
        pulse_frame_start();
        serve_burst(8'hFF, CMD_IDLE, -1, -1, 24'h010000, addr, cmd, len, pushes, bad, to);
        serve_burst(8'hFF, CMD_IDLE, -1, -1, 24'h020000, addr, cmd, len, pushes, bad, to);
        serve_burst(8'hFF, CMD_IDLE, -1, -1, 24'h030000, addr, cmd, len, pushes, bad, to);
        n_checks++; if (addr !== 32'h1400) begin n_fail++; $display("FAIL fsmid_line1 got=%h exp=1400", addr); end
        fd0 = fd_cnt;
        serve_burst(8'hFF, CMD_IDLE, -1, 1, 24'h040000, addr, cmd, len, pushes, bad, to);
        n_checks++; if (addr !== 32'h1410 || pushes != 4 || bad != 0) begin n_fail++; $display("FAIL fsmid_last got=%h/%0d/%0d exp=1410/4/0", addr, pushes, bad); end
        serve_burst(8'hFF, CMD_IDLE, -1, -1, 24'h050000, addr, cmd, len, pushes, bad, to);
        n_checks++; if (to !== 1'b0 || addr !== 32'h1000) begin n_fail++; $display("FAIL fsmid_restart got=%h to=%b exp=1000/0", addr, to); end
        repeat (2) @(negedge clk);
        n_checks++; if (fd_cnt != fd0) begin n_fail++; $display("FAIL fsmid_no_done got=%0d exp=0", fd_cnt - fd0); end
    endtask

    task automatic test_reset_mid_data();
        int w, wr0, bad_req;
        w = 0;
        while (bus_if.reqout !== REQ_BID && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_checks++; if (bus_if.reqout !== REQ_BID) begin n_fail++; $display("FAIL rstmid_bid got=%b exp=11", bus_if.reqout); end
        bus_if.ackin = 1'b1;
        @(negedge clk);
        bus_if.ackin = 1'b0;
        n_checks++; if (bus_if.cmdout !== CMD_RD || bus_if.addrdataout !== 32'h1010) begin n_fail++; $display("FAIL rstmid_addr got=%b/%h exp=010/1010", bus_if.cmdout, bus_if.addrdataout); end
        @(negedge clk);
        bus_if.cmdin = CMD_RDDATA; bus_if.addrdatain = 32'h00AB_CDEF;
        @(negedge clk);
        n_checks++; if (bus_if.fifo_write !== 1'b1 || bus_if.fifo_data !== 24'hABCDEF) begin n_fail++; $display("FAIL rstmid_beat0 got=%b/%h exp=1/abcdef", bus_if.fifo_write, bus_if.fifo_data); end
        bus_if.addrdatain = 32'h0011_2233;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (bus_if.reqout !== 2'b00 || bus_if.cmdout !== 3'b000 || bus_if.lenout !== 2'b00 ||
            bus_if.addrdataout !== 32'h0 || bus_if.fifo_write !== 1'b0 || bus_if.fifo_data !== 24'h0 ||
            busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_zero got=%b %b %b %h %b %h %b %b exp=all zero", bus_if.reqout, bus_if.cmdout,
                     bus_if.lenout, bus_if.addrdataout, bus_if.fifo_write, bus_if.fifo_data, busy, frame_done);
        end
        wr0 = wr_cnt; bad_req = 0;
        repeat (2) @(negedge clk);
        bus_if.cmdin = CMD_IDLE; bus_if.addrdatain = '0;
        repeat (5) begin
            @(negedge clk);
            if (bus_if.reqout !== 2'b00) bad_req++;
        end
        n_checks++; if (wr_cnt != wr0 || bad_req != 0) begin n_fail++; $display("FAIL rstmid_dropped got=%0d writes %0d bids exp=0/0", wr_cnt - wr0, bad_req); end
    endtask

    task automatic test_zero_size();
        int bad_cyc;
        hsize = 13'd0;
        pulse_frame_start();
        bad_cyc = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.reqout !== 2'b00 || busy !== 1'b0) bad_cyc++;
        end
        pulse_frame_start();
        repeat (6) begin
            @(negedge clk);
            if (bus_if.reqout !== 2'b00 || busy !== 1'b0) bad_cyc++;
        end
        n_checks++; if (bad_cyc != 0) begin n_fail++; $display("FAIL zero_size got=%0d active cycles exp=0", bad_cyc); end
        hsize = 13'd8;
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int   w;
        logic seen;
        pulse_frame_start();
        seen = 1'b0; w = 0;
        while (!seen && w < 400) begin
            @(negedge clk);
            w++;
            if (fetch_err === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen || bus_if.reqout !== 2'b00) begin n_fail++; $display("FAIL timeout_err got=%b/%b exp=1/00", seen, bus_if.reqout); end
        @(negedge clk);
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse got=%b exp=0", fetch_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_credit();
        test_beat_gaps();
        test_en_drop();
        test_frame_start_mid();
        test_reset_mid_data();
        test_zero_size();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
